axi_lite_arbiter: RTL
=====================

# axi_lite_arbiter

Two-master, one-slave AXI4-Lite arbiter between the core's instruction fetch unit (master 0, read-only) and load/store unit (master 1, read/write) and the single memory slave (`Mem`). Grants exactly one transaction at a time, routes the slave's responses back to the granted master, and holds the grant until that transaction's response handshake completes. This serialises fetches and data accesses onto the one memory port.

## Interface
Parameters:
- `AW`, 32, address width on all ports
- `DW`, 32, data width on all ports

Ports (`mN_*` exists for both masters unless marked m1-only):
- `clk`  input  1  single clock, rising edge
- `rst`  input  1  reset, asynchronous, active-high
- `mN_araddr / mN_arvalid / mN_arready`  in/in/out  AW/1/1  master read-address channel
- `mN_rdata / mN_rresp / mN_rvalid / mN_rready`  out/out/out/in  DW/2/1/1  master read-data channel
- `m1_awaddr / m1_awvalid / m1_awready`  in/in/out  AW/1/1  m1-only write-address channel
- `m1_wdata / m1_wstrb / m1_wvalid / m1_wready`  in/in/in/out  DW/4/1/1  m1-only write-data channel
- `m1_bresp / m1_bvalid / m1_bready`  out/out/in  2/1/1  m1-only write-response channel
- `s_*`  mirror of the full m1 port set with directions reversed, connected to `Mem`

## Operation
- State register `st` takes one of four values: IDLE, RD0 (m0 read granted), RD1 (m1 read granted), WR1 (m1 write granted).
- In IDLE, candidate requests are `req_w = m1_awvalid & m1_wvalid`, `req_r1 = m1_arvalid`, `req_r0 = m0_arvalid`.
- Fixed priority in IDLE: `req_w` > `req_r1` > `req_r0`. The next state is registered.
- RD0 / RD1:
  - The granted master's AR and R channels are wired straight through to `s_`.
  - Flag `a_done` sets on `s_arvalid & s_arready`. While `a_done` is set, `s_arvalid` is forced to 0 and the master's `arready` is forced to 0.
  - On `s_rvalid & s_rready`, go to IDLE and clear `a_done`.
- WR1:
  - m1's AW, W and B channels pass through.
  - `s_awvalid` and `s_wvalid` are both gated to 0 after AW/W fire. `Mem` requires AW and W to fire in the same cycle; the arbiter does not split them.
  - On `s_bvalid & s_bready`, go to IDLE.
- All non-granted channels:
  - Slave-side valids are 0.
  - Master-side `ready`/`valid` outputs are 0.
  - Data and resp outputs carry the slave value unmodified, which is don't-care.
- Reads and writes are never outstanding together.
- `rresp`/`bresp` pass through unchanged. Error responses do not alter arbitration.
- A master dropping `valid` before its grant is legal and is simply not granted. Dropping `valid` after grant but before its AR/AW fire is an AXI protocol violation and is not handled.

## Timing
- Reset (asynchronous): `st` = IDLE, `a_done` = 0, `rr_last` = 0. Every valid/ready output is 0 immediately, with no clock edge needed.
- Arbitration latency is 1 cycle. A request first sampled in IDLE at edge N is granted in cycle N+1, and its `s_arvalid`/`s_awvalid` is asserted combinationally in that cycle.
- The return to IDLE happens on the edge after the response fire. The minimum gap between back-to-back transactions is therefore 1 idle cycle.
- If a request arrives in the same cycle as the response fire, it is not seen until IDLE.
- If `rst` asserts mid-transaction, the grant is abandoned. The slave is reset by the same `rst`.
- There is no combinational path from any master input to another master's outputs.

## Configuration
- `ARB_RR_EN`:
  - Defined: round-robin between m0 and m1. Register `rr_last` (0 = m0, 1 = m1) updates on each grant.
  - With `ARB_RR_EN` defined, when m0 and m1 both request in IDLE, the master that was not last granted wins.
  - Within m1, a write still beats a read.
  - Undefined: fixed priority as in Operation, and `rr_last` is not instantiated.

## Test plan
- Single m0 read of 0x8000_0000 with slave delay 5 → `s_arvalid` in cycle 1; `m0_rdata` equals slave data; `m0_rvalid` is high exactly 1 cycle; `st` returns to IDLE.
- m0 and m1 assert `arvalid` in the same IDLE cycle, `ARB_RR_EN` undefined → m1 is granted first; m0 is granted 1 cycle after m1's R fire. Throughout, `m0_arready` stays 0 while m1 holds the grant.
- Same stimulus with `ARB_RR_EN` defined and `rr_last` = 1 → m0 is granted first, then m1.
- m1 write 0xDEADBEEF to 0x8000_0004 with `wstrb` = 0xF → `s_awvalid` and `s_wvalid` fire in the same cycle; `m1_bvalid` is high for 1 cycle with `bresp` = 0; a readback through m0 returns 0xDEADBEEF.
- m1 asserts write and read together → the write is granted first and the read follows, with no overlap of `s_arvalid` and `s_awvalid`.
- `rst` pulsed asynchronously during RD0 while waiting for R → all valid/ready outputs drop to 0 before the next edge; `st` = IDLE; the next request is granted normally.

Source files
------------

// File: rtl/axi_lite_arbiter.sv
// Two-master / one-slave AXI4-Lite arbiter: one transaction in flight, grant held until its response fires.
// Optional ARB_RR_EN selects round-robin between m0 and m1; the default build uses fixed priority (m1 write > m1 read > m0 read).
module axi_lite_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  // master 0: instruction fetch, read-only
  input  logic [AW-1:0] m0_araddr,
  input  logic          m0_arvalid,
  output logic          m0_arready,
  output logic [DW-1:0] m0_rdata,
  output logic [1:0]    m0_rresp,
  output logic          m0_rvalid,
  input  logic          m0_rready,
  // master 1: load/store, read/write
  input  logic [AW-1:0] m1_araddr,
  input  logic          m1_arvalid,
  output logic          m1_arready,
  output logic [DW-1:0] m1_rdata,
  output logic [1:0]    m1_rresp,
  output logic          m1_rvalid,
  input  logic          m1_rready,
  input  logic [AW-1:0] m1_awaddr,
  input  logic          m1_awvalid,
  output logic          m1_awready,
  input  logic [DW-1:0] m1_wdata,
  input  logic [3:0]    m1_wstrb,
  input  logic          m1_wvalid,
  output logic          m1_wready,
  output logic [1:0]    m1_bresp,
  output logic          m1_bvalid,
  input  logic          m1_bready,
  // slave: Mem
  output logic [AW-1:0] s_araddr,
  output logic          s_arvalid,
  input  logic          s_arready,
  input  logic [DW-1:0] s_rdata,
  input  logic [1:0]    s_rresp,
  input  logic          s_rvalid,
  output logic          s_rready,
  output logic [AW-1:0] s_awaddr,
  output logic          s_awvalid,
  input  logic          s_awready,
  output logic [DW-1:0] s_wdata,
  output logic [3:0]    s_wstrb,
  output logic          s_wvalid,
  input  logic          s_wready,
  input  logic [1:0]    s_bresp,
  input  logic          s_bvalid,
  output logic          s_bready
);

  typedef enum logic [1:0] {IDLE, RD0, RD1, WR1} st_t;

  st_t  st;
  logic a_done;

  logic req_w, req_r1, req_r0, m1_req, pick_m0;
  logic rd0, rd1, wr1;

  assign req_w  = m1_awvalid & m1_wvalid;
  assign req_r1 = m1_arvalid;
  assign req_r0 = m0_arvalid;
  assign m1_req = req_w | req_r1;

`ifdef ARB_RR_EN
  logic rr_last;

  // On contention m0 wins only if m1 was the last master granted.
  assign pick_m0 = req_r0 & (~m1_req | rr_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last <= 1'b0;
    end else if (st == IDLE) begin
      if (pick_m0) begin
        rr_last <= 1'b0;
      end else if (m1_req) begin
        rr_last <= 1'b1;
      end
    end
  end
`else
  assign pick_m0 = req_r0 & ~m1_req;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st     <= IDLE;
      a_done <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (pick_m0) begin
            st <= RD0;
          end else if (req_w) begin
            st <= WR1;
          end else if (req_r1) begin
            st <= RD1;
          end
        end
        RD0, RD1: begin
          if (s_arvalid & s_arready) begin
            a_done <= 1'b1;
          end
          if (s_rvalid & s_rready) begin
            st     <= IDLE;
            a_done <= 1'b0;
          end
        end
        WR1: begin
          // Mem takes AW and W together, so one flag covers both channels.
          if (s_awvalid & s_awready & s_wvalid & s_wready) begin
            a_done <= 1'b1;
          end
          if (s_bvalid & s_bready) begin
            st     <= IDLE;
            a_done <= 1'b0;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign rd0 = (st == RD0);
  assign rd1 = (st == RD1);
  assign wr1 = (st == WR1);

  // Read path: address/handshakes of the granted reader only.
  assign s_araddr   = rd1 ? m1_araddr : m0_araddr;
  assign s_arvalid  = ((rd0 & m0_arvalid) | (rd1 & m1_arvalid)) & ~a_done;
  assign m0_arready = rd0 & ~a_done & s_arready;
  assign m1_arready = rd1 & ~a_done & s_arready;
  assign s_rready   = (rd0 & m0_rready) | (rd1 & m1_rready);

  assign m0_rdata  = s_rdata;
  assign m0_rresp  = s_rresp;
  assign m0_rvalid = rd0 & s_rvalid;
  assign m1_rdata  = s_rdata;
  assign m1_rresp  = s_rresp;
  assign m1_rvalid = rd1 & s_rvalid;

  // Write path: only m1 writes.
  assign s_awaddr   = m1_awaddr;
  assign s_wdata    = m1_wdata;
  assign s_wstrb    = m1_wstrb;
  assign s_awvalid  = wr1 & m1_awvalid & ~a_done;
  assign s_wvalid   = wr1 & m1_wvalid & ~a_done;
  assign m1_awready = wr1 & ~a_done & s_awready;
  assign m1_wready  = wr1 & ~a_done & s_wready;
  assign m1_bresp   = s_bresp;
  assign m1_bvalid  = wr1 & s_bvalid;
  assign s_bready   = wr1 & m1_bready;

endmodule
